// File: rtl/rggen_apb_host_ctrl_if.sv
// APB slave signals plus the flat register-bus request/response toward address decode.
// The slave modport is the host adapter's view; master is the APB/decode environment's view.
interface rggen_apb_host_ctrl_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                      i_psel;
  logic                      i_penable;
  logic                      i_pwrite;
  logic [ADDRESS_WIDTH-1:0]  i_paddr;
  logic [DATA_WIDTH/8-1:0]   i_pstrb;
  logic [DATA_WIDTH-1:0]     i_pwdata;
  logic                      o_pready;
  logic [DATA_WIDTH-1:0]     o_prdata;
  logic                      o_pslverr;
  logic                      o_reg_valid;
  logic                      o_reg_write;
  logic [ADDRESS_WIDTH-1:0]  o_reg_address;
  logic [DATA_WIDTH/8-1:0]   o_reg_strobe;
  logic [DATA_WIDTH-1:0]     o_reg_write_data;
  logic                      i_reg_hit;
  logic                      i_reg_ready;
  logic                      i_reg_error;
  logic [DATA_WIDTH-1:0]     i_reg_read_data;

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pstrb, i_pwdata,
    output o_pready, o_prdata, o_pslverr,
    output o_reg_valid, o_reg_write, o_reg_address, o_reg_strobe, o_reg_write_data,
    input  i_reg_hit, i_reg_ready, i_reg_error, i_reg_read_data
  );

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pstrb, i_pwdata,
    input  o_pready, o_prdata, o_pslverr,
    input  o_reg_valid, o_reg_write, o_reg_address, o_reg_strobe, o_reg_write_data,
    output i_reg_hit, i_reg_ready, i_reg_error, i_reg_read_data
  );
endinterface

// File: rtl/rggen_apb_host_ctrl.sv
// APB slave -> single-outstanding register bus; pready 2 cycles after setup at best, all APB outputs registered.
// ACCESS holds until ready, miss or PSEL abort; RGGEN_APB_HOST_TIMEOUT_EN adds a watchdog that ends a stuck access.
module rggen_apb_host_ctrl #(
  parameter int ADDRESS_WIDTH     = 8,
  parameter int DATA_WIDTH        = 32,
  parameter bit ERROR_ON_UNMAPPED = 1'b1,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input logic                  clk,
  input logic                  rst,
  rggen_apb_host_ctrl_if.slave bus
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPOND
  } state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic                     w_setup;
  logic                     w_timeout;
  logic                     w_pready_next;
  logic [DATA_WIDTH-1:0]    w_prdata_next;
  logic                     w_pslverr_next;

  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [SW-1:0]            r_strobe;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic                     r_pready;
  logic [DATA_WIDTH-1:0]    r_prdata;
  logic                     r_pslverr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_setup        = 1'b0;
    w_pready_next  = 1'b0;
    w_prdata_next  = '0;
    w_pslverr_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_psel && !bus.i_penable) begin
          w_setup      = 1'b1;
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Abort outranks every completion source: the master has already left.
        if (!bus.i_psel) begin
          w_state_next = ST_IDLE;
        end else if (!bus.i_reg_hit) begin
          w_state_next   = ST_RESPOND;
          w_pready_next  = 1'b1;
          w_pslverr_next = ERROR_ON_UNMAPPED;
        end else if (bus.i_reg_ready) begin
          w_state_next   = ST_RESPOND;
          w_pready_next  = 1'b1;
          w_pslverr_next = bus.i_reg_error;
          w_prdata_next  = r_write ? '0 : bus.i_reg_read_data;
        end else if (w_timeout) begin
          w_state_next   = ST_RESPOND;
          w_pready_next  = 1'b1;
          w_pslverr_next = 1'b1;
        end
      end
      ST_RESPOND: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_address    <= '0;
      r_strobe     <= '0;
      r_write_data <= '0;
    end else if (w_setup) begin
      r_write      <= bus.i_pwrite;
      r_address    <= bus.i_paddr & ADDR_MASK;
      r_strobe     <= bus.i_pwrite ? bus.i_pstrb : '1;
      r_write_data <= bus.i_pwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_pready_next;
      r_prdata  <= w_prdata_next;
      r_pslverr <= w_pslverr_next;
    end
  end

`ifdef RGGEN_APB_HOST_TIMEOUT_EN
  logic [TW-1:0] r_wdog_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_count <= '0;
    end else if (w_setup) begin
      r_wdog_count <= '0;
    end else if ((r_state == ST_ACCESS) && (w_state_next == ST_ACCESS)) begin
      r_wdog_count <= r_wdog_count + 1'b1;
    end
  end

  assign w_timeout = (r_wdog_count == TW'(TIMEOUT_CYCLES - 1));
`else
  logic [TW-1:0] w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = TW'(TIMEOUT_CYCLES);
  assign w_timeout            = 1'b0;
`endif

  assign bus.o_pready         = r_pready;
  assign bus.o_prdata         = r_prdata;
  assign bus.o_pslverr        = r_pslverr;
  assign bus.o_reg_valid      = (r_state == ST_ACCESS);
  assign bus.o_reg_write      = r_write;
  assign bus.o_reg_address    = r_address;
  assign bus.o_reg_strobe     = r_strobe;
  assign bus.o_reg_write_data = r_write_data;
endmodule

// File: tb/tb_rggen_apb_host_ctrl.sv
// Bench for rggen_apb_host_ctrl: two instances (miss -> error / miss -> OK) share one APB stimulus stream.
module tb_rggen_apb_host_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] pwdata = '0;
  logic        hit = 1'b0, ready = 1'b0, rerr = 1'b0;
  logic [31:0] rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rggen_apb_host_ctrl_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) if_e ();
  rggen_apb_host_ctrl_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) if_o ();

  assign if_e.i_psel = psel;    assign if_o.i_psel = psel;
  assign if_e.i_penable = penable; assign if_o.i_penable = penable;
  assign if_e.i_pwrite = pwrite;  assign if_o.i_pwrite = pwrite;
  assign if_e.i_paddr = paddr;    assign if_o.i_paddr = paddr;
  assign if_e.i_pstrb = pstrb;    assign if_o.i_pstrb = pstrb;
  assign if_e.i_pwdata = pwdata;  assign if_o.i_pwdata = pwdata;
  assign if_e.i_reg_hit = hit;    assign if_o.i_reg_hit = hit;
  assign if_e.i_reg_ready = ready; assign if_o.i_reg_ready = ready;
  assign if_e.i_reg_error = rerr; assign if_o.i_reg_error = rerr;
  assign if_e.i_reg_read_data = rdata; assign if_o.i_reg_read_data = rdata;

  rggen_apb_host_ctrl #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .ERROR_ON_UNMAPPED(1'b1), .TIMEOUT_CYCLES(4)
  ) dut_e (.clk(clk), .rst(rst), .bus(if_e));

  rggen_apb_host_ctrl #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .ERROR_ON_UNMAPPED(1'b0), .TIMEOUT_CYCLES(4)
  ) dut_o (.clk(clk), .rst(rst), .bus(if_o));

  typedef struct {
    string       name;
    bit          write;
    logic [7:0]  addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          hit;
    int          wait_cyc;
    logic [31:0] rdata;
    bit          err;
    logic [7:0]  exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_prdata;
    bit          exp_err_e;
    bit          exp_err_o;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] prdata;
    bit          err_e;
    bit          err_o;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic score(input string nm, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check({nm, "_unexpected_pready"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({nm, "_prdata_e"}, if_e.o_prdata, e.prdata);
      check({nm, "_pslverr_e"}, if_e.o_pslverr, e.err_e);
      check({nm, "_prdata_o"}, if_o.o_prdata, e.prdata);
      check({nm, "_pslverr_o"}, if_o.o_pslverr, e.err_o);
      check({nm, "_pready_o"}, if_o.o_pready, 1);
      check({nm, "_latency"}, lat, e.lat);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    int lat;
    bit done;
    exp_t e;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = v.write; paddr = v.addr; pstrb = v.strb;
    pwdata = v.wdata; hit = v.hit; ready = 1'b0; rerr = v.err; rdata = v.rdata;
    e = '{v.exp_prdata, v.exp_err_e, v.exp_err_o, v.exp_lat};
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    check({v.name, "_valid"}, if_e.o_reg_valid, 1);
    check({v.name, "_write"}, if_e.o_reg_write, v.write);
    check({v.name, "_address"}, if_e.o_reg_address, v.exp_addr);
    check({v.name, "_strobe"}, if_e.o_reg_strobe, v.exp_strb);
    if (v.write) check({v.name, "_wdata"}, if_e.o_reg_write_data, v.wdata);
    ready = (v.wait_cyc == 0);
    lat = 1;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (if_e.o_pready) begin
        done = 1'b1;
        score(v.name, lat);
      end else begin
        ready = ((lat - 1) == v.wait_cyc);
      end
    end
    ready = 1'b0;
    if (!done) begin
      check({v.name, "_pready_seen"}, 0, 1);
      e = sb.pop_back();
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_pready_e"}, if_e.o_pready, 0);
    check({nm, "_prdata_e"}, if_e.o_prdata, 0);
    check({nm, "_pslverr_e"}, if_e.o_pslverr, 0);
    check({nm, "_valid_e"}, if_e.o_reg_valid, 0);
    check({nm, "_regs_e"}, {if_e.o_reg_write, if_e.o_reg_address, if_e.o_reg_strobe,
                            if_e.o_reg_write_data}, 0);
    check({nm, "_all_o"}, {if_o.o_pready, if_o.o_prdata, if_o.o_pslverr, if_o.o_reg_valid,
                           if_o.o_reg_write, if_o.o_reg_address, if_o.o_reg_strobe}, 0);
  endtask

`ifdef RGGEN_APB_HOST_TIMEOUT_EN
  localparam int NV = 8;
`else
  localparam int NV = 7;
`endif
  vec_t tbl[NV];
  vec_t v;

  initial begin
    bit seen;
    //           name       wr addr   strb   wdata         hit wait rdata         err eaddr  estrb  eprdata       ee eo lat
    tbl[0] = '{"rd_hit",    0, 8'h10, 4'h0, 32'h0,        1, 0,   32'hA5A50F0F, 0, 8'h10, 4'hF, 32'hA5A50F0F, 0, 0, 2};
    tbl[1] = '{"wr_07",     1, 8'h07, 4'h3, 32'h12345678, 1, 3,   32'hDEADBEEF, 0, 8'h04, 4'h3, 32'h0,        0, 0, 5};
    tbl[2] = '{"rd_miss",   0, 8'h20, 4'h0, 32'h0,        0, 0,   32'hFFFFFFFF, 0, 8'h20, 4'hF, 32'h0,        1, 0, 2};
    tbl[3] = '{"rd_err",    0, 8'h2E, 4'h5, 32'h0,        1, 1,   32'h0BADF00D, 1, 8'h2C, 4'hF, 32'h0BADF00D, 1, 1, 3};
    tbl[4] = '{"wr_err",    1, 8'hFF, 4'h8, 32'hCAFEF00D, 1, 2,   32'h11111111, 1, 8'hFC, 4'h8, 32'h0,        1, 1, 4};
    tbl[5] = '{"wr_miss",   1, 8'h33, 4'hF, 32'h87654321, 0, 0,   32'h22222222, 0, 8'h30, 4'hF, 32'h0,        1, 0, 2};
`ifdef RGGEN_APB_HOST_TIMEOUT_EN
    tbl[6] = '{"rd_wdog",   0, 8'h40, 4'h0, 32'h0,        1, 255, 32'hFFFFFFFF, 0, 8'h40, 4'hF, 32'h0,        1, 1, 5};
    tbl[7] = '{"rd_rdy4",   0, 8'h44, 4'h0, 32'h0,        1, 3,   32'h76543210, 0, 8'h44, 4'hF, 32'h76543210, 0, 0, 5};
`else
    tbl[6] = '{"rd_nowdog", 0, 8'h48, 4'h0, 32'h0,        1, 20,  32'h13572468, 0, 8'h48, 4'hF, 32'h13572468, 0, 0, 22};
`endif

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Back-to-back: every transfer's setup lands in the IDLE cycle after the previous response.
    for (int i = 0; i < NV; i++) do_xfer(tbl[i]);

    @(negedge clk);
    check("post_resp_pready", if_e.o_pready, 0);
    check("post_resp_prdata", if_e.o_prdata, 0);
    check("post_resp_pslverr", if_e.o_pslverr, 0);
    psel = 1'b0; penable = 1'b0;

    // PSEL dropped in the second ACCESS cycle.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h18; hit = 1'b1; ready = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    check("abort_valid_before", if_e.o_reg_valid, 1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_valid_after", if_e.o_reg_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (if_e.o_pready || if_o.o_pready) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_pready", seen, 0);
    v = '{"after_abort", 0, 8'h1C, 4'h0, 32'h0, 1, 0, 32'h600DCAFE, 0, 8'h1C, 4'hF, 32'h600DCAFE, 0, 0, 2};
    do_xfer(v);

    // Reset in the middle of ACCESS, with ready arriving the same cycle.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0D; pstrb = 4'h6;
    pwdata = 32'h55AA55AA; hit = 1'b1; ready = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0; psel = 1'b0; penable = 1'b0; ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if_e.o_pready || if_e.o_reg_valid) seen = 1'b1;
    end
    check("rst_mid_quiet", seen, 0);
    v = '{"after_rst", 1, 8'h0D, 4'h6, 32'h55AA55AA, 1, 1, 32'h0, 0, 8'h0C, 4'h6, 32'h0, 0, 0, 3};
    do_xfer(v);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
